// File: rtl/draw_rect_sequencer_if.sv
// Bundles the command handshake, status and DrawPoint master signals of draw_rect_sequencer.
// Latency: none; this is wiring only.
// Backpressure: cmd_valid/cmd_ready handshake on the command side; the DrawPoint side is strobe-only.
interface draw_rect_sequencer_if;
    // command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x0;
    logic [8:0]  cmd_y0;
    logic [8:0]  cmd_x1;
    logic [8:0]  cmd_y1;
    logic [11:0] cmd_rgb;
    logic        cmd_fill;
    logic        abort;

    // status
    logic        busy;
    logic        done;
    logic [18:0] points;

    // DrawPoint master
    logic        coe_dpm_ul1Clock;
    logic        coe_dpm_ul1Reset_n;
    logic        coe_dpm_ul1Update;
    logic [8:0]  coe_dpm_ul9PosX;
    logic [8:0]  coe_dpm_ul9PosY;
    logic [11:0] coe_dpm_ul12Rgb12Data;

    // command source / pixel-writer side
    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_rgb, cmd_fill, abort,
        input  cmd_ready, busy, done, points,
        input  coe_dpm_ul1Clock, coe_dpm_ul1Reset_n, coe_dpm_ul1Update,
        input  coe_dpm_ul9PosX, coe_dpm_ul9PosY, coe_dpm_ul12Rgb12Data
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_rgb, cmd_fill, abort,
        output cmd_ready, busy, done, points,
        output coe_dpm_ul1Clock, coe_dpm_ul1Reset_n, coe_dpm_ul1Update,
        output coe_dpm_ul9PosX, coe_dpm_ul9PosY, coe_dpm_ul12Rgb12Data
    );
endinterface

// File: rtl/draw_rect_sequencer.sv
// Turns one rectangle command (fill or outline, any corner order) into a clipped raster of DrawPoint updates.
// Latency: handshake at T, LOAD at T+1, first update at T+2, then one update every 1+GAP cycles; done after the last.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are not captured; abort returns to IDLE silently.
module draw_rect_sequencer #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239,
    parameter int GAP   = 0
) (
    input  logic                 csi_clock_clk,
    input  logic                 rsi_reset_reset,
    draw_rect_sequencer_if.slave bus
);

    localparam logic [8:0] X_LIM    = 9'(X_MAX);
    localparam logic [8:0] Y_LIM    = 9'(Y_MAX);
    localparam bit         HAS_GAP  = (GAP > 0);
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // captured command
    logic [8:0]  cap_x0;
    logic [8:0]  cap_y0;
    logic [8:0]  cap_x1;
    logic [8:0]  cap_y1;
    logic [11:0] cap_rgb;
    logic        cap_fill;

    // normalized, clipped bounds and the raster cursor
    logic [8:0]  xa;
    logic [8:0]  xb;
    logic [8:0]  ya;
    logic [8:0]  yb;
    logic [8:0]  cur_x;
    logic [8:0]  cur_y;

    logic [3:0]  gap_cnt;
    logic [18:0] point_cnt;

    // last emitted point, held on the DrawPoint bus between updates
    logic [8:0]  held_x;
    logic [8:0]  held_y;
    logic [11:0] held_rgb;

    // LOAD-stage corner arithmetic
    logic [8:0]  lo_x;
    logic [8:0]  hi_x;
    logic [8:0]  lo_y;
    logic [8:0]  hi_y;
    logic [8:0]  clip_xb;
    logic [8:0]  clip_yb;
    logic        off_screen;

    // DRAW-stage stepping
    logic        last_point;
    logic        interior_row;
    logic [8:0]  nxt_x;
    logic [8:0]  nxt_y;

    logic        handshake;
    logic        updating;

    assign handshake = (state == IDLE) && bus.cmd_valid;
    assign updating  = (state == DRAW);

    // Normalize corners, clip the far edge, and work out the next raster position.
    always_comb begin
        lo_x         = (cap_x0 < cap_x1) ? cap_x0 : cap_x1;
        hi_x         = (cap_x0 < cap_x1) ? cap_x1 : cap_x0;
        lo_y         = (cap_y0 < cap_y1) ? cap_y0 : cap_y1;
        hi_y         = (cap_y0 < cap_y1) ? cap_y1 : cap_y0;
        clip_xb      = (hi_x > X_LIM) ? X_LIM : hi_x;
        clip_yb      = (hi_y > Y_LIM) ? Y_LIM : hi_y;
        // the near corner off-screen means nothing at all is visible
        off_screen   = (lo_x > X_LIM) || (lo_y > Y_LIM);

        last_point   = (cur_x == xb) && (cur_y == yb);
        // outline rows strictly between top and bottom only carry the two side pixels
        interior_row = !cap_fill && (cur_y != ya) && (cur_y != yb);

        nxt_x = cur_x + 9'd1;
        nxt_y = cur_y;
        if (cur_x == xb) begin
            nxt_x = xa;
            nxt_y = cur_y + 9'd1;
        end else if (interior_row) begin
            // jump across the hollow interior without spending cycles on it
            nxt_x = xb;
        end
    end

    // State register.
    always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
        if (rsi_reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides everything in the working states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (off_screen) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (last_point) begin
                    state_nxt = DONE;
                end else if (HAS_GAP) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = DRAW;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nxt = DRAW;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the command on the handshake; later offers are ignored until IDLE.
    always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
        if (rsi_reset_reset) begin
            cap_x0   <= '0;
            cap_y0   <= '0;
            cap_x1   <= '0;
            cap_y1   <= '0;
            cap_rgb  <= '0;
            cap_fill <= 1'b0;
        end else if (handshake) begin
            cap_x0   <= bus.cmd_x0;
            cap_y0   <= bus.cmd_y0;
            cap_x1   <= bus.cmd_x1;
            cap_y1   <= bus.cmd_y1;
            cap_rgb  <= bus.cmd_rgb;
            cap_fill <= bus.cmd_fill;
        end
    end

    // Latch the clipped bounds in LOAD and walk the cursor on every update.
    always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
        if (rsi_reset_reset) begin
            xa    <= '0;
            xb    <= '0;
            ya    <= '0;
            yb    <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (state == LOAD) begin
            xa    <= lo_x;
            xb    <= clip_xb;
            ya    <= lo_y;
            yb    <= clip_yb;
            cur_x <= lo_x;
            cur_y <= lo_y;
        end else if (updating && !last_point) begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
        end
    end

    // Inter-update idle counter, restarted on every update.
    always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
        if (rsi_reset_reset) begin
            gap_cnt <= '0;
        end else if (updating) begin
            gap_cnt <= '0;
        end else if (state == WAIT) begin
            gap_cnt <= gap_cnt + 4'd1;
        end
    end

    // Count emitted points and remember the last one; the count survives abort and done.
    always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
        if (rsi_reset_reset) begin
            point_cnt <= '0;
            held_x    <= '0;
            held_y    <= '0;
            held_rgb  <= '0;
        end else if (handshake) begin
            point_cnt <= '0;
        end else if (updating) begin
            point_cnt <= point_cnt + 19'd1;
            held_x    <= cur_x;
            held_y    <= cur_y;
            held_rgb  <= cap_rgb;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.points    = point_cnt;

    assign bus.coe_dpm_ul1Clock      = csi_clock_clk;
    assign bus.coe_dpm_ul1Reset_n    = ~rsi_reset_reset;
    assign bus.coe_dpm_ul1Update     = updating;
    // live cursor during an update, last emitted point otherwise
    assign bus.coe_dpm_ul9PosX       = updating ? cur_x   : held_x;
    assign bus.coe_dpm_ul9PosY       = updating ? cur_y   : held_y;
    assign bus.coe_dpm_ul12Rgb12Data = updating ? cap_rgb : held_rgb;

endmodule

// File: tb/tb_draw_rect_sequencer.sv
// Drives two sequencers (GAP=0 and GAP=2) with directed and random rectangles and scores them against a raster model.
// Latency: checks exact update and done cycles relative to the handshake cycle.
// Backpressure: offers a stray command during LOAD and expects it to be refused.
module tb_draw_rect_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    draw_rect_sequencer_if if0();
    draw_rect_sequencer_if if2();

    draw_rect_sequencer #(.X_MAX(319), .Y_MAX(239), .GAP(0)) dut0 (
        .csi_clock_clk   (clk),
        .rsi_reset_reset (rst),
        .bus             (if0)
    );

    draw_rect_sequencer #(.X_MAX(319), .Y_MAX(239), .GAP(2)) dut2 (
        .csi_clock_clk   (clk),
        .rsi_reset_reset (rst),
        .bus             (if2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor records: {cycle, x, y, rgb}
    logic [61:0] obs0[$];
    logic [61:0] obs2[$];
    int dn0 = 0, dn2 = 0, dc0 = 0, dc2 = 0, hn0 = 0, hn2 = 0, hs0 = 0, hs2 = 0;

    always @(negedge clk) begin
        if (if0.coe_dpm_ul1Update)
            obs0.push_back({32'(cyc), if0.coe_dpm_ul9PosX, if0.coe_dpm_ul9PosY, if0.coe_dpm_ul12Rgb12Data});
        if (if2.coe_dpm_ul1Update)
            obs2.push_back({32'(cyc), if2.coe_dpm_ul9PosX, if2.coe_dpm_ul9PosY, if2.coe_dpm_ul12Rgb12Data});
        if (if0.done) begin dn0++; dc0 = cyc; end
        if (if2.done) begin dn2++; dc2 = cyc; end
        if (if0.cmd_valid && if0.cmd_ready) begin hn0++; hs0 = cyc; end
        if (if2.cmd_valid && if2.cmd_ready) begin hn2++; hs2 = cyc; end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        obs0.delete();
        obs2.delete();
        dn0 = 0; dn2 = 0; hn0 = 0; hn2 = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_upd0"},  64'(if0.coe_dpm_ul1Update), 64'd0);
        chk({tag, "_upd2"},  64'(if2.coe_dpm_ul1Update), 64'd0);
        chk({tag, "_busy0"}, 64'(if0.busy), 64'd0);
        chk({tag, "_busy2"}, 64'(if2.busy), 64'd0);
        chk({tag, "_rdy0"},  64'(if0.cmd_ready), 64'd1);
        chk({tag, "_rdy2"},  64'(if2.cmd_ready), 64'd1);
        chk({tag, "_done0"}, 64'(if0.done), 64'd0);
        chk({tag, "_pts0"},  64'(if0.points), 64'd0);
        chk({tag, "_pts2"},  64'(if2.points), 64'd0);
        chk({tag, "_pos0"},  64'({if0.coe_dpm_ul9PosX, if0.coe_dpm_ul9PosY, if0.coe_dpm_ul12Rgb12Data}), 64'd0);
        chk({tag, "_pos2"},  64'({if2.coe_dpm_ul9PosX, if2.coe_dpm_ul9PosY, if2.coe_dpm_ul12Rgb12Data}), 64'd0);
        chk({tag, "_rstn"},  64'(if0.coe_dpm_ul1Reset_n), 64'd0);
    endtask

    // Offer one command, then offer junk during LOAD which must be refused.
    task automatic start_cmd(input int x0, input int y0, input int x1, input int y1,
                             input logic [11:0] c, input logic f, input logic e0, input logic e2);
        @(posedge clk); #1;
        clear_mon();
        if0.cmd_x0 = 9'(x0); if0.cmd_y0 = 9'(y0); if0.cmd_x1 = 9'(x1); if0.cmd_y1 = 9'(y1);
        if0.cmd_rgb = c; if0.cmd_fill = f;
        if2.cmd_x0 = 9'(x0); if2.cmd_y0 = 9'(y0); if2.cmd_x1 = 9'(x1); if2.cmd_y1 = 9'(y1);
        if2.cmd_rgb = c; if2.cmd_fill = f;
        if0.cmd_valid = e0;
        if2.cmd_valid = e2;
        @(posedge clk); #1;
        if0.cmd_x0 = 9'h1FF; if0.cmd_y0 = 9'h1FF; if0.cmd_rgb = ~c; if0.cmd_fill = ~f;
        if2.cmd_x0 = 9'h1FF; if2.cmd_y0 = 9'h1FF; if2.cmd_rgb = ~c; if2.cmd_fill = ~f;
        @(negedge clk);
        if (e0) chk("rdy_load0", 64'(if0.cmd_ready), 64'd0);
        if (e2) chk("rdy_load2", 64'(if2.cmd_ready), 64'd0);
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        if2.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input logic e0, input logic e2);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((e0 && if0.busy) || (e2 && if2.busy)) && k < 3000);
        chk("idle", 64'({e0 && if0.busy, e2 && if2.busy}), 64'd0);
    endtask

    // Reference: enumerate the clipped rectangle in raster order, keeping edge pixels only for outlines.
    task automatic verify(input int which, input int x0, input int y0, input int x1, input int y1,
                          input logic [11:0] c, input logic f);
        logic [61:0] got[$];
        logic [63:0] exp;
        int g, hs, dn, dc, n, pts, xa, xb, ya, yb;
        logic [29:0] held;
        if (which == 0) begin
            got = obs0; g = 0; hs = hs0; dn = dn0; dc = dc0; pts = int'(if0.points);
            held = {if0.coe_dpm_ul9PosX, if0.coe_dpm_ul9PosY, if0.coe_dpm_ul12Rgb12Data};
            chk("hs_n0", 64'(hn0), 64'd1);
        end else begin
            got = obs2; g = 2; hs = hs2; dn = dn2; dc = dc2; pts = int'(if2.points);
            held = {if2.coe_dpm_ul9PosX, if2.coe_dpm_ul9PosY, if2.coe_dpm_ul12Rgb12Data};
            chk("hs_n2", 64'(hn2), 64'd1);
        end
        xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
        if (xb > 319) xb = 319;
        if (yb > 239) yb = 239;
        n = 0;
        if (xa <= 319 && ya <= 239) begin
            for (int yy = ya; yy <= yb; yy++) begin
                for (int xx = xa; xx <= xb; xx++) begin
                    if (f || yy == ya || yy == yb || xx == xa || xx == xb) begin
                        exp = 64'({32'(hs + 2 + n * (1 + g)), 9'(xx), 9'(yy), c});
                        if (n < got.size())
                            chk($sformatf("pt%0d_%0d", which, n), 64'(got[n]), exp);
                        n++;
                    end
                end
            end
        end
        chk($sformatf("count%0d", which), 64'(got.size()), 64'(n));
        chk($sformatf("points%0d", which), 64'(pts), 64'(n));
        chk($sformatf("done_n%0d", which), 64'(dn), 64'd1);
        chk($sformatf("done_cyc%0d", which), 64'(dc),
            64'((n == 0) ? hs + 2 : hs + 3 + (n - 1) * (1 + g)));
        if (n > 0)
            chk($sformatf("hold%0d", which), 64'(held), 64'({9'(xb), 9'(yb), c}));
    endtask

    task automatic run(input int x0, input int y0, input int x1, input int y1,
                       input logic [11:0] c, input logic f);
        start_cmd(x0, y0, x1, y1, c, f, 1'b1, 1'b1);
        wait_idle(1'b1, 1'b1);
        verify(0, x0, y0, x1, y1, c, f);
        verify(2, x0, y0, x1, y1, c, f);
    endtask

    // Abort a 10x10 fill in the cycle of its 3rd update.
    task automatic abort_test(input int which);
        int n = 0;
        int k = 0;
        logic upd;
        start_cmd(0, 0, 9, 9, 12'h5A5, 1'b1, which == 0, which == 2);
        do begin
            @(negedge clk);
            upd = (which == 0) ? if0.coe_dpm_ul1Update : if2.coe_dpm_ul1Update;
            if (upd) n++;
            k++;
        end while (n < 3 && k < 60);
        if (which == 0) if0.abort = 1'b1; else if2.abort = 1'b1;
        @(posedge clk); #1;
        if0.abort = 1'b0;
        if2.abort = 1'b0;
        @(negedge clk);
        chk($sformatf("ab_rdy%0d", which), 64'((which == 0) ? if0.cmd_ready : if2.cmd_ready), 64'd1);
        chk($sformatf("ab_busy%0d", which), 64'((which == 0) ? if0.busy : if2.busy), 64'd0);
        repeat (40) @(negedge clk);
        chk($sformatf("ab_upd%0d", which), 64'((which == 0) ? obs0.size() : obs2.size()), 64'd3);
        chk($sformatf("ab_done%0d", which), 64'((which == 0) ? dn0 : dn2), 64'd0);
        chk($sformatf("ab_pts%0d", which), 64'((which == 0) ? if0.points : if2.points), 64'd3);
    endtask

    initial begin
        int x0, y0, x1, y1, t;
        if0.cmd_valid = 1'b0; if0.abort = 1'b0; if0.cmd_fill = 1'b0; if0.cmd_rgb = '0;
        if0.cmd_x0 = '0; if0.cmd_y0 = '0; if0.cmd_x1 = '0; if0.cmd_y1 = '0;
        if2.cmd_valid = 1'b0; if2.abort = 1'b0; if2.cmd_fill = 1'b0; if2.cmd_rgb = '0;
        if2.cmd_x0 = '0; if2.cmd_y0 = '0; if2.cmd_x1 = '0; if2.cmd_y1 = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rstn_rel", 64'(if0.coe_dpm_ul1Reset_n), 64'd1);
        chk("clk_fwd", 64'(if0.coe_dpm_ul1Clock), 64'd0);

        run(5, 7, 5, 7, 12'h123, 1'b1);
        run(4, 3, 2, 2, 12'hF0A, 1'b1);
        run(10, 10, 13, 13, 12'h0C3, 1'b0);
        run(318, 238, 400, 300, 12'h777, 1'b1);
        run(320, 0, 330, 5, 12'h111, 1'b1);
        run(0, 0, 2, 0, 12'hABC, 1'b1);
        run(9, 5, 3, 5, 12'h246, 1'b0);
        run(7, 6, 7, 1, 12'h135, 1'b0);
        run(20, 21, 21, 20, 12'h9E1, 1'b0);
        run(100, 250, 110, 300, 12'h808, 1'b0);

        for (int i = 0; i < 24; i++) begin
            x0 = $urandom_range(0, 335);
            y0 = $urandom_range(0, 250);
            x1 = x0 + $urandom_range(0, 9);
            y1 = y0 + $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin t = x0; x0 = x1; x1 = t; end
            if ($urandom_range(0, 1) == 1) begin t = y0; y0 = y1; y1 = t; end
            run(x0, y0, x1, y1, 12'($urandom), 1'($urandom));
        end

        abort_test(0);
        abort_test(2);

        start_cmd(0, 0, 9, 9, 12'hFFF, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("arst");
        @(negedge clk);
        rst = 1'b0;
        run(1, 2, 1, 2, 12'h42A, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
